key_autorepeat: RTL and testbench

Per-button press/auto-repeat generator placed directly downstream of the debouncer in the input path. It takes debounced button levels and emits single-cycle press, action and release pulses. Action pulses follow a delayed-auto-shift (DAS) then auto-repeat-rate (ARR) schedule, so game logic sees one move per pulse regardless of how long a key is held. Channels excluded from repeat (rotate, hard drop) give exactly one action per press.

---
 rtl/input_pkg.sv | 17 +
 rtl/autorepeat_channel.sv | 92 +++++++++
 rtl/key_autorepeat.sv | 35 +++
 tb/tb_key_autorepeat.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared types and timing defaults for the button input path.
package input_pkg;

  typedef enum logic [1:0] {AR_IDLE, AR_DELAY, AR_REPEAT} ar_state_t;

  localparam int CLK_HZ         = 25_000_000;
  localparam int DAS_CYCLES_DEF = 4_250_000;
  localparam int ARR_CYCLES_DEF = 1_250_000;

  // Counter width wide enough for the larger of the two terminal counts.
  function automatic int cnt_w(input int das, input int arr);
    int m;
    m = (das > arr) ? das : arr;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/autorepeat_channel.sv
// One button channel: edge detect plus DAS/ARR repeat schedule, registered pulses.
module autorepeat_channel
  import input_pkg::*;
#(
  parameter int DAS_CYCLES = DAS_CYCLES_DEF,
  parameter int ARR_CYCLES = ARR_CYCLES_DEF,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic action,
  output logic rel,
  output logic held
);

  localparam int CW = cnt_w(DAS_CYCLES, ARR_CYCLES);
  localparam logic [CW-1:0] DAS_TC = CW'(DAS_CYCLES - 1);
  localparam logic [CW-1:0] ARR_TC = CW'(ARR_CYCLES - 1);

  ar_state_t       state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            prev;
  logic            press_d, action_d, rel_d;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    press_d  = 1'b0;
    action_d = 1'b0;
    rel_d    = 1'b0;
    unique case (state)
      AR_IDLE: begin
        if (btn && !prev) begin
          press_d  = 1'b1;
          action_d = 1'b1;
          cnt_d    = '0;
          state_d  = AR_DELAY;
        end
      end
      AR_DELAY: begin
        // Release takes priority over a coincident terminal count.
        if (!btn) begin
          rel_d   = 1'b1;
          state_d = AR_IDLE;
        end else if (cnt == DAS_TC) begin
          if (REPEAT_EN) begin
            action_d = 1'b1;
            cnt_d    = '0;
            state_d  = AR_REPEAT;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      AR_REPEAT: begin
        if (!btn) begin
          rel_d   = 1'b1;
          state_d = AR_IDLE;
        end else if (cnt == ARR_TC) begin
          action_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= AR_IDLE;
      cnt    <= '0;
      prev   <= 1'b0;
      press  <= 1'b0;
      action <= 1'b0;
      rel    <= 1'b0;
      held   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      prev   <= btn;
      press  <= press_d;
      action <= action_d;
      rel    <= rel_d;
      held   <= (state_d != AR_IDLE);
    end
  end

endmodule

// File: rtl/key_autorepeat.sv
// N independent press/auto-repeat channels behind the debouncer.
module key_autorepeat
  import input_pkg::*;
#(
  parameter int             N           = 2,
  parameter int             DAS_CYCLES  = DAS_CYCLES_DEF,
  parameter int             ARR_CYCLES  = ARR_CYCLES_DEF,
  parameter logic [N-1:0]   REPEAT_MASK = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] press,
  output logic [N-1:0] action,
  output logic [N-1:0] rel,
  output logic [N-1:0] held
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    autorepeat_channel #(
      .DAS_CYCLES(DAS_CYCLES),
      .ARR_CYCLES(ARR_CYCLES),
      .REPEAT_EN (REPEAT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[i]),
      .press (press[i]),
      .action(action[i]),
      .rel   (rel[i]),
      .held  (held[i])
    );
  end

endmodule

// File: tb/tb_key_autorepeat.sv
// Directed bench: DAS=8, ARR=3, channel 1 excluded from repeat.
module tb_key_autorepeat;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] press, action, rel, held;

  int checks = 0;
  int errors = 0;

  key_autorepeat #(
    .N(2), .DAS_CYCLES(8), .ARR_CYCLES(3), .REPEAT_MASK(2'b01)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .press(press), .action(action), .rel(rel), .held(held)
  );

  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after the edge that produced them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b1;
    btn = 2'b00;
    repeat (3) tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold got=%b want=%b", o, 8'h00);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      o = {press, action, rel, held};
      checks++;
      if (o !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle k=%0d got=%b want=%b", k, o, 8'h00);
      end
    end
  endtask

  task automatic test_repeat();
    logic [7:0] o, e;
    btn = 2'b01;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b01, 2'b01, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL repeat_press got=%b want=%b", o, {2'b01, 2'b01, 2'b00, 2'b01});
    end
    // press at P; repeats at P+8, P+11, P+14, ... up to P+29
    for (int k = 1; k < 30; k++) begin
      tick();
      e = {2'b00, (k == 8 || k == 11 || k == 14 || k == 17 || k == 20 ||
                   k == 23 || k == 26 || k == 29) ? 2'b01 : 2'b00, 2'b00, 2'b01};
      o = {press, action, rel, held};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL repeat_hold k=%0d got=%b want=%b", k, o, e);
      end
    end
    btn = 2'b00;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b00, 2'b00, 2'b01, 2'b00}) begin
      errors++;
      $display("FAIL repeat_release got=%b want=%b", o, {2'b00, 2'b00, 2'b01, 2'b00});
    end
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL repeat_after got=%b want=%b", o, 8'h00);
    end
  endtask

  task automatic test_no_repeat();
    logic [7:0] o;
    int acts;
    btn = 2'b10;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b10, 2'b10, 2'b00, 2'b10}) begin
      errors++;
      $display("FAIL norep_press got=%b want=%b", o, {2'b10, 2'b10, 2'b00, 2'b10});
    end
    acts = 0;
    for (int k = 1; k < 30; k++) begin
      tick();
      if (action != 2'b00 || press != 2'b00 || rel != 2'b00 || held != 2'b10) acts++;
    end
    checks++;
    if (acts !== 0) begin
      errors++;
      $display("FAIL norep_hold bad_cycles got=%0d want=0", acts);
    end
    btn = 2'b00;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b00, 2'b00, 2'b10, 2'b00}) begin
      errors++;
      $display("FAIL norep_release got=%b want=%b", o, {2'b00, 2'b00, 2'b10, 2'b00});
    end
    tick();
  endtask

  task automatic test_release_at_tc();
    logic [7:0] o;
    btn = 2'b01;
    tick();                // press; cnt=0
    repeat (7) tick();     // cnt reaches DAS-1
    btn = 2'b00;           // drop on the terminal-count edge
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b00, 2'b00, 2'b01, 2'b00}) begin
      errors++;
      $display("FAIL tc_release got=%b want=%b", o, {2'b00, 2'b00, 2'b01, 2'b00});
    end
    // Back in idle: a fresh press must be recognised immediately.
    tick();
    btn = 2'b01;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b01, 2'b01, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL tc_idle_repress got=%b want=%b", o, {2'b01, 2'b01, 2'b00, 2'b01});
    end
    btn = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] o;
    int bad;
    btn = 2'b01;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b01, 2'b01, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL b2b_press1 got=%b want=%b", o, {2'b01, 2'b01, 2'b00, 2'b01});
    end
    btn = 2'b00;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b00, 2'b00, 2'b01, 2'b00}) begin
      errors++;
      $display("FAIL b2b_release got=%b want=%b", o, {2'b00, 2'b00, 2'b01, 2'b00});
    end
    btn = 2'b01;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b01, 2'b01, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL b2b_press2 got=%b want=%b", o, {2'b01, 2'b01, 2'b00, 2'b01});
    end
    bad = 0;
    for (int k = 1; k < 8; k++) begin
      tick();
      if (action != 2'b00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_das_early got=%0d want=0", bad);
    end
    tick();
    checks++;
    if (action !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first_repeat got=%b want=%b", action, 2'b01);
    end
    btn = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] o;
    btn = 2'b01;
    tick();
    repeat (10) tick();    // now in repeat
    checks++;
    if (held !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid_held got=%b want=%b", held, 2'b01);
    end
    rst = 1'b1;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_abort got=%b want=%b", o, 8'h00);
    end
    rst = 1'b0;
    tick();
    o = {press, action, rel, held};
    checks++;
    if (o !== {2'b01, 2'b01, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL rst_mid_repress got=%b want=%b", o, {2'b01, 2'b01, 2'b00, 2'b01});
    end
    btn = 2'b00;
    tick();
    checks++;
    if (rel !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid_release got=%b want=%b", rel, 2'b01);
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 2'b00;
    test_reset();
    test_repeat();
    test_no_repeat();
    test_release_at_tc();
    test_back_to_back();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
